sema_phase_scheduler: RTL and testbench
=======================================

Name: sema_phase_scheduler

Overview:
- Timed phase sequencer and round-robin arbiter for a three-approach signalized crossing: west road (W), south road (S) and pedestrian crossing (P).
- Latches sticky requests from the W, S and P detectors and grants right-of-way to one approach at a time.
- Each grant runs through a green/walk, yellow/clear and all-red sequence.
- Timing counts pulses of a divided-clock enable `tick` supplied by the top level. Light outputs drive the lamp drivers directly.

Parameters:
- GREEN_T, 8: minimum W/S green duration, in ticks (≥1).
- YELLOW_T, 3: W/S yellow duration, in ticks (≥1).
- WALK_T, 6: pedestrian walk duration, in ticks (≥1).
- PCLR_T, 2: pedestrian clearance duration, in ticks (≥1). During clearance, p_gr is red and both roads are red.
- ALLRED_T, 1: all-red interval between grants, in ticks (≥1).
- CNT_W, 4: timer width. Every duration must be ≤ 2^CNT_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-clk-wide timing enable from the clock divider
- p  in  1  pedestrian request, level, may be asynchronous-slow (already debounced)
- w  in  1  west vehicle request
- s  in  1  south vehicle request
- w_gyr  out  3  west lamps {green, yellow, red}
- s_gyr  out  3  south lamps {green, yellow, red}
- p_gr  out  2  pedestrian lamps {walk(green), dont-walk(red)}
- pend  out  3  pending request flags {p, s, w}
- phase  out  3  current state code, for debug

Behaviour:
- States and codes:
  - IDLE=0
  - W_GRN=1, W_YEL=2
  - S_GRN=3, S_YEL=4
  - P_WALK=5, P_CLR=6
  - ALL_RED=7
- Outputs are Moore, registered. Lamps decode from the state register only.
  - IDLE, ALL_RED, P_CLR: w_gyr=001, s_gyr=001, p_gr=01.
  - W_GRN: w_gyr=100. W_YEL: w_gyr=010. Other lamps stay red in both.
  - S_GRN / S_YEL: same pattern on s_gyr.
  - P_WALK: p_gr=10. Both roads show 001.
  - No two approaches are ever non-red simultaneously. This is a hard invariant.
- Reset, applied on the next clk edge:
  - state=IDLE, pend=000, timer=0.
  - Round-robin pointer last=P, so W has first priority.
  - Outputs all-red. Reset mid-phase aborts immediately to all-red.
- Request latching:
  - Every clk, pend[x] is set if input x=1.
  - pend[x] is cleared on the edge that enters x's green/walk state.
  - While in x's green/walk state, input x is ignored; pend[x] is not set.
  - During x's yellow/clear, input x re-latches.
- Timer:
  - On every state entry, timer loads duration−1.
  - On a clk with tick=1 and timer≠0, timer decrements.
  - Expiry means tick=1 and timer==0. The transition occurs on that same clk edge.
  - Without tick, the state never advances. Request latching still operates.
- Arbitration (IDLE, or ALL_RED at expiry):
  - Candidates are scanned starting after `last`, in order W→S→P→W.
  - The first pending candidate is granted. `last` updates to the granted approach.
  - IDLE with pend≠0: grant on the next tick=1 clk. No timer is involved.
  - ALL_RED at expiry with pend=0 → IDLE.
- Transitions:
  - W_GRN at expiry:
    - if pend[s]|pend[p] → W_YEL;
    - else rest in green (timer held at 0) until another request latches, then → W_YEL on the next tick.
  - S_GRN: same rule, with the competitors being w and p.
  - W_YEL / S_YEL at expiry → ALL_RED.
  - P_WALK at expiry → P_CLR. The walk phase never rests.
  - P_CLR at expiry → ALL_RED.
- Simultaneous events:
  - Multiple pending requests are granted in round-robin order.
  - A request arriving on the same clk as arbitration is visible to it, because pend is set combinationally into the arbitration.
- pend output reflects the registered flags.

Test Plan:
- Reset then idle: reset=1 for 2 clk, release, tick every 4 clk, no requests → phase=0, all lamps red (001/001/01) for 100 clk.
- Single west request: pulse w for 1 clk, tick every clk → next tick phase=1 with w_gyr=100, pend=000. Green rests after 8 ticks while no other request.
- Preemption of rest:
  - Starting from the previous case, pulse s.
  - Expected: next tick W_YEL for 3 ticks, then ALL_RED 1 tick, then S_GRN.
- Round-robin with all three requests at once:
  - p=w=s=1 for 1 clk after reset.
  - Expected grant order: W, S, P.
  - P sequence: walk for 6 ticks, clearance for 2 ticks, then ALL_RED, then IDLE with pend=000.
- Re-latch rules: hold w=1 continuously from W_GRN through W_YEL → pend[w]=0 during W_GRN, pend[w]=1 after entering W_YEL.
- Reset mid-phase and invariant:
  - Assert reset during S_YEL → next clk all-red, phase=0, pend=000.
  - Random p/w/s/tick for 10k clk.
  - Assertion: never two approaches non-red simultaneously.

Source files
------------

// File: rtl/sema_phase_scheduler_if.sv
// Signal bundle between the crossing controller and its surroundings:
// detector requests and divider tick in, lamp drives and debug state out.
interface sema_phase_scheduler_if;
    logic       tick;
    logic       p;
    logic       w;
    logic       s;
    logic [2:0] w_gyr;
    logic [2:0] s_gyr;
    logic [1:0] p_gr;
    logic [2:0] pend;
    logic [2:0] phase;

    modport master (
        output tick, p, w, s,
        input  w_gyr, s_gyr, p_gr, pend, phase
    );

    modport slave (
        input  tick, p, w, s,
        output w_gyr, s_gyr, p_gr, pend, phase
    );
endinterface

// File: rtl/sema_phase_scheduler.sv
// Three-approach crossing sequencer: sticky W/S/P requests, round-robin
// grants, green/yellow/all-red timing counted in divider ticks.
module sema_phase_scheduler #(
    parameter int unsigned GREEN_T  = 8,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned WALK_T   = 6,
    parameter int unsigned PCLR_T   = 2,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    sema_phase_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_GRN   = 3'd1,
        W_YEL   = 3'd2,
        S_GRN   = 3'd3,
        S_YEL   = 3'd4,
        P_WALK  = 3'd5,
        P_CLR   = 3'd6,
        ALL_RED = 3'd7
    } state_t;

    localparam logic [1:0] AP_W = 2'd0;
    localparam logic [1:0] AP_S = 2'd1;
    localparam logic [1:0] AP_P = 2'd2;

    localparam logic [7:0] LAMPS_RED = 8'b001_001_01;

    state_t           state;
    state_t           state_nx;
    state_t           grant_st;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nx;
    logic [2:0]       pend_q;
    logic [2:0]       pend_nx;
    logic [2:0]       pend_lat;
    logic [2:0]       req;
    logic [2:0]       grant;
    logic [2:0]       clr;
    logic [1:0]       last;
    logic [1:0]       last_nx;
    logic             expire;
    logic             entering;
    logic [7:0]       lamps_q;

    // Scan order starts just after the previous winner.
    function automatic logic [2:0] rr_pick(
        input logic [1:0] lst,
        input logic [2:0] pd
    );
        logic [2:0] r;
        r = 3'b000;
        case (lst)
            AP_W: begin
                if (pd[1])      r = 3'b010;
                else if (pd[2]) r = 3'b100;
                else if (pd[0]) r = 3'b001;
            end
            AP_S: begin
                if (pd[2])      r = 3'b100;
                else if (pd[0]) r = 3'b001;
                else if (pd[1]) r = 3'b010;
            end
            default: begin
                if (pd[0])      r = 3'b001;
                else if (pd[1]) r = 3'b010;
                else if (pd[2]) r = 3'b100;
            end
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] dur_of(input state_t st);
        logic [CNT_W-1:0] d;
        unique case (st)
            W_GRN, S_GRN:  d = CNT_W'(GREEN_T - 1);
            W_YEL, S_YEL:  d = CNT_W'(YELLOW_T - 1);
            P_WALK:        d = CNT_W'(WALK_T - 1);
            P_CLR:         d = CNT_W'(PCLR_T - 1);
            ALL_RED:       d = CNT_W'(ALLRED_T - 1);
            default:       d = '0;
        endcase
        return d;
    endfunction

    // {w_gyr, s_gyr, p_gr}
    function automatic logic [7:0] lamps_of(input state_t st);
        logic [7:0] l;
        unique case (st)
            W_GRN:   l = 8'b100_001_01;
            W_YEL:   l = 8'b010_001_01;
            S_GRN:   l = 8'b001_100_01;
            S_YEL:   l = 8'b001_010_01;
            P_WALK:  l = 8'b001_001_10;
            default: l = LAMPS_RED;
        endcase
        return l;
    endfunction

    // An approach's own detector is ignored while it holds right-of-way.
    always_comb begin
        req[0] = bus.w && (state != W_GRN);
        req[1] = bus.s && (state != S_GRN);
        req[2] = bus.p && (state != P_WALK);
    end

    assign pend_lat = pend_q | req;
    assign grant    = rr_pick(last, pend_lat);
    assign expire   = bus.tick && (timer == '0);

    always_comb begin
        grant_st = IDLE;
        unique case (1'b1)
            grant[0]: grant_st = W_GRN;
            grant[1]: grant_st = S_GRN;
            grant[2]: grant_st = P_WALK;
            default:  grant_st = IDLE;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.tick && (grant != 3'b000))
                    state_nx = grant_st;
            end
            W_GRN: begin
                if (expire && (pend_lat[1] || pend_lat[2]))
                    state_nx = W_YEL;
            end
            S_GRN: begin
                if (expire && (pend_lat[0] || pend_lat[2]))
                    state_nx = S_YEL;
            end
            W_YEL, S_YEL, P_CLR: begin
                if (expire)
                    state_nx = ALL_RED;
            end
            P_WALK: begin
                if (expire)
                    state_nx = P_CLR;
            end
            ALL_RED: begin
                if (expire)
                    state_nx = grant_st;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign entering = (state_nx != state);

    always_comb begin
        clr     = 3'b000;
        last_nx = last;
        if (entering) begin
            unique case (state_nx)
                W_GRN: begin
                    clr     = 3'b001;
                    last_nx = AP_W;
                end
                S_GRN: begin
                    clr     = 3'b010;
                    last_nx = AP_S;
                end
                P_WALK: begin
                    clr     = 3'b100;
                    last_nx = AP_P;
                end
                default: begin
                    clr     = 3'b000;
                    last_nx = last;
                end
            endcase
        end
    end

    assign pend_nx = pend_lat & ~clr;

    // A resting green sits at zero, so the next tick is already expiry.
    always_comb begin
        timer_nx = timer;
        if (entering)
            timer_nx = dur_of(state_nx);
        else if (bus.tick && (timer != '0))
            timer_nx = timer - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            pend_q  <= 3'b000;
            last    <= AP_P;
            lamps_q <= LAMPS_RED;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            pend_q  <= pend_nx;
            last    <= last_nx;
            lamps_q <= lamps_of(state_nx);
        end
    end

    assign bus.w_gyr = lamps_q[7:5];
    assign bus.s_gyr = lamps_q[4:2];
    assign bus.p_gr  = lamps_q[1:0];
    assign bus.pend  = pend_q;
    assign bus.phase = state;

endmodule

// File: tb/tb_sema_phase_scheduler.sv
// Directed and random stimulus for the crossing sequencer, checking
// phase codes, lamp patterns, pending flags and the one-green invariant.
module tb_sema_phase_scheduler;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sema_phase_scheduler_if bus();

    sema_phase_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_lamps(input logic [2:0] ph);
        logic [7:0] l;
        case (ph)
            3'd1:    l = 8'b100_001_01;
            3'd2:    l = 8'b010_001_01;
            3'd3:    l = 8'b001_100_01;
            3'd4:    l = 8'b001_010_01;
            3'd5:    l = 8'b001_001_10;
            default: l = 8'b001_001_01;
        endcase
        return l;
    endfunction

    task automatic clk_step(input logic t, input logic pp,
                            input logic ww, input logic ss);
        bus.tick = t;
        bus.p    = pp;
        bus.w    = ww;
        bus.s    = ss;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk_step(1'b0, 1'b0, 1'b0, 1'b0);
        clk_step(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.phase !== 3'd0 || bus.pend !== 3'b000) begin
            failures++;
            $display("FAIL reset_state phase=%0d pend=%b want 0/000",
                     bus.phase, bus.pend);
        end
        for (int i = 0; i < 100; i++) begin
            clk_step((i % 4) == 0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.phase !== 3'd0 ||
                {bus.w_gyr, bus.s_gyr, bus.p_gr} !== 8'b001_001_01) begin
                failures++;
                $display("FAIL idle_red cyc=%0d phase=%0d lamps=%b_%b_%b want 0 001_001_01",
                         i, bus.phase, bus.w_gyr, bus.s_gyr, bus.p_gr);
            end
        end
    endtask

    task automatic test_single_west();
        do_reset();
        clk_step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.phase !== 3'd1 || bus.pend !== 3'b000 ||
            {bus.w_gyr, bus.s_gyr, bus.p_gr} !== 8'b100_001_01) begin
            failures++;
            $display("FAIL west_grant phase=%0d pend=%b lamps=%b_%b_%b want 1 000 100_001_01",
                     bus.phase, bus.pend, bus.w_gyr, bus.s_gyr, bus.p_gr);
        end
        for (int i = 0; i < 20; i++)
            clk_step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.phase !== 3'd1 || bus.w_gyr !== 3'b100) begin
            failures++;
            $display("FAIL west_rest phase=%0d w_gyr=%b want 1 100",
                     bus.phase, bus.w_gyr);
        end
    endtask

    task automatic test_preempt();
        clk_step(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.phase !== 3'd2 || bus.pend !== 3'b010 ||
            bus.w_gyr !== 3'b010) begin
            failures++;
            $display("FAIL preempt_yel phase=%0d pend=%b w_gyr=%b want 2 010 010",
                     bus.phase, bus.pend, bus.w_gyr);
        end
        for (int i = 0; i < 3; i++)
            clk_step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.phase !== 3'd2) begin
            failures++;
            $display("FAIL no_tick_hold phase=%0d want 2", bus.phase);
        end
        clk_step(1'b1, 1'b0, 1'b0, 1'b0);
        clk_step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.phase !== 3'd2) begin
            failures++;
            $display("FAIL yel_len phase=%0d want 2", bus.phase);
        end
        clk_step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.phase !== 3'd7 ||
            {bus.w_gyr, bus.s_gyr, bus.p_gr} !== 8'b001_001_01) begin
            failures++;
            $display("FAIL all_red phase=%0d lamps=%b_%b_%b want 7 001_001_01",
                     bus.phase, bus.w_gyr, bus.s_gyr, bus.p_gr);
        end
        clk_step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.phase !== 3'd3 || bus.pend !== 3'b000 ||
            bus.s_gyr !== 3'b100 || bus.w_gyr !== 3'b001) begin
            failures++;
            $display("FAIL s_grant phase=%0d pend=%b s_gyr=%b w_gyr=%b want 3 000 100 001",
                     bus.phase, bus.pend, bus.s_gyr, bus.w_gyr);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] ph  [9] = '{3'd1, 3'd2, 3'd7, 3'd3, 3'd4,
                                3'd7, 3'd5, 3'd6, 3'd7};
        int         dur [9] = '{8, 3, 1, 8, 3, 1, 6, 2, 1};
        do_reset();
        clk_step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.phase !== 3'd1 || bus.pend !== 3'b110) begin
            failures++;
            $display("FAIL rr_first phase=%0d pend=%b want 1 110",
                     bus.phase, bus.pend);
        end
        for (int g = 0; g < 9; g++) begin
            for (int k = 0; k < dur[g]; k++) begin
                checks++;
                if (bus.phase !== ph[g] ||
                    {bus.w_gyr, bus.s_gyr, bus.p_gr} !== exp_lamps(ph[g])) begin
                    failures++;
                    $display("FAIL rr_seq seg=%0d k=%0d phase=%0d lamps=%b_%b_%b want %0d %b",
                             g, k, bus.phase, bus.w_gyr, bus.s_gyr, bus.p_gr,
                             ph[g], exp_lamps(ph[g]));
                end
                clk_step(1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
        checks++;
        if (bus.phase !== 3'd0 || bus.pend !== 3'b000) begin
            failures++;
            $display("FAIL rr_idle phase=%0d pend=%b want 0 000",
                     bus.phase, bus.pend);
        end
    endtask

    task automatic test_relatch();
        do_reset();
        clk_step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.phase !== 3'd1 || bus.pend[0] !== 1'b0) begin
                failures++;
                $display("FAIL relatch_grn i=%0d phase=%0d pend=%b want 1 pend[w]=0",
                         i, bus.phase, bus.pend);
            end
            clk_step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        clk_step(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.phase !== 3'd2 || bus.pend !== 3'b010) begin
            failures++;
            $display("FAIL relatch_enter phase=%0d pend=%b want 2 010",
                     bus.phase, bus.pend);
        end
        clk_step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.phase !== 3'd2 || bus.pend !== 3'b011) begin
            failures++;
            $display("FAIL relatch_yel phase=%0d pend=%b want 2 011",
                     bus.phase, bus.pend);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clk_step(1'b1, 1'b0, 1'b0, 1'b1);
        clk_step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++)
            clk_step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.phase !== 3'd4 || bus.s_gyr !== 3'b010) begin
            failures++;
            $display("FAIL reach_s_yel phase=%0d s_gyr=%b want 4 010",
                     bus.phase, bus.s_gyr);
        end
        clk_step(1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        clk_step(1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if (bus.phase !== 3'd0 || bus.pend !== 3'b000 ||
            {bus.w_gyr, bus.s_gyr, bus.p_gr} !== 8'b001_001_01) begin
            failures++;
            $display("FAIL reset_mid phase=%0d pend=%b lamps=%b_%b_%b want 0 000 001_001_01",
                     bus.phase, bus.pend, bus.w_gyr, bus.s_gyr, bus.p_gr);
        end
    endtask

    task automatic test_random();
        int nonred;
        for (int i = 0; i < 10000; i++) begin
            clk_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            nonred = int'(bus.w_gyr != 3'b001) + int'(bus.s_gyr != 3'b001) +
                     int'(bus.p_gr != 2'b01);
            checks++;
            if (nonred > 1 ||
                {bus.w_gyr, bus.s_gyr, bus.p_gr} !== exp_lamps(bus.phase)) begin
                failures++;
                $display("FAIL rand_invariant cyc=%0d phase=%0d lamps=%b_%b_%b nonred=%0d want <=1",
                         i, bus.phase, bus.w_gyr, bus.s_gyr, bus.p_gr, nonred);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.tick = 1'b0;
        bus.p    = 1'b0;
        bus.w    = 1'b0;
        bus.s    = 1'b0;
        test_reset();
        test_single_west();
        test_preempt();
        test_round_robin();
        test_relatch();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
